// File: rtl/led_pkg.sv
// Shared constants for the POV LED shift driver: register map, CTRL bit positions, serializer states.
package led_pkg;

  localparam int unsigned BUS_W       = 32;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_CLKDIV = 1;
  localparam int unsigned ADDR_CH0    = 2;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_START  = 1;
  localparam int unsigned CTRL_AUTO   = 2;
  localparam int unsigned CTRL_BUSY   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_LATCH
  } led_state_e;

endpackage

// File: rtl/led_serializer.sv
// Frame serializer: snapshots one frame word and divider on start, then shifts it out MSB first
// as LOW/HIGH sclk phases of div+1 cycles each, followed by a latch phase and a done pulse.
module led_serializer
  import led_pkg::*;
#(
  parameter int unsigned NUM_BITS = 16,
  parameter int unsigned DIV_W    = 8
) (
  input  logic                csi_clk,
  input  logic                rsi_reset,
  input  logic                start,
  input  logic [DIV_W-1:0]    div,
  input  logic [NUM_BITS-1:0] frame,
  output logic                sclk,
  output logic                sdata,
  output logic                latch,
  output logic                busy,
  output logic                done
);

  localparam int unsigned     BIT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);

  led_state_e          state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    phase_q, phase_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic                sclk_d, sdata_d, latch_d, busy_d, done_d;

  // State, datapath and pin registers
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk    <= sclk_d;
      sdata   <= sdata_d;
      latch   <= latch_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state; pins are decoded from the next state so they line up with the state register
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = 1'b0;
    sdata_d = 1'b0;
    latch_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOW;
          div_d   = div;
          shreg_d = frame;
          phase_d = '0;
          bit_d   = '0;
        end
      end
      ST_LOW: begin
        if (phase_q == div_q) begin
          phase_d = '0;
          state_d = ST_HIGH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_q == div_q) begin
          phase_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = ST_LATCH;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q << 1;
            state_d = ST_LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (phase_q == div_q) begin
          phase_d = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_LOW:   sdata_d = shreg_d[NUM_BITS-1];
      ST_HIGH: begin
        sclk_d  = 1'b1;
        sdata_d = shreg_d[NUM_BITS-1];
      end
      ST_LATCH: latch_d = 1'b1;
      default:  ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: rtl/led_shift_driver.sv
// Avalon-MM LED driver for the POV display: CTRL/CLKDIV/channel register file with registered
// readback, START/AUTO frame triggering, and the frame serializer driving the LED chain.
module led_shift_driver
  import led_pkg::*;
#(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [BUS_W-1:0]  avs_writedata,
  input  logic              avs_read,
  output logic [BUS_W-1:0]  avs_readdata,
  output logic              led_sclk,
  output logic              led_sdata,
  output logic              led_latch,
  output logic              led_en,
  output logic              frame_done
);

  localparam int unsigned NUM_BITS = NUM_CH * DATA_W;

  logic                           ctrl_en_q, ctrl_auto_q;
  logic [DIV_W-1:0]               clkdiv_q;
  logic [NUM_CH-1:0][DATA_W-1:0]  ch_q;
  logic [NUM_CH:0][BUS_W-1:0]     ch_rd_c;
  logic [BUS_W-1:0]               rd_mux_c;
  logic                           wr_ctrl_c, wr_div_c, start_c, busy;
  logic                           unused_wdata_c;

  assign wr_ctrl_c      = avs_write && (avs_address == ADDR_W'(ADDR_CTRL));
  assign wr_div_c       = avs_write && (avs_address == ADDR_W'(ADDR_CLKDIV));
  assign unused_wdata_c = ^avs_writedata;

  // START only acts in IDLE (serializer ignores it otherwise); AUTO restarts from the done cycle
  assign start_c = (wr_ctrl_c && avs_writedata[CTRL_START]) || (frame_done && ctrl_auto_q);

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      ctrl_en_q   <= 1'b0;
      ctrl_auto_q <= 1'b0;
      clkdiv_q    <= DIV_W'(DEF_DIV);
    end else begin
      if (wr_ctrl_c) begin
        ctrl_en_q   <= avs_writedata[CTRL_EN];
        ctrl_auto_q <= avs_writedata[CTRL_AUTO];
      end
      if (wr_div_c) begin
        clkdiv_q <= avs_writedata[DIV_W-1:0];
      end
    end
  end

  assign ch_rd_c[0] = '0;

  // Channel registers; packed so CH[NUM_CH-1] lands in the frame MSBs
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic hit_c;
    assign hit_c = (avs_address == ADDR_W'(ADDR_CH0 + g));

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
        ch_q[g] <= '0;
      end else if (avs_write && hit_c) begin
        ch_q[g] <= avs_writedata[DATA_W-1:0];
      end
    end

    assign ch_rd_c[g+1] = ch_rd_c[g] | (hit_c ? BUS_W'(ch_q[g]) : '0);
  end

  always_comb begin
    rd_mux_c = ch_rd_c[NUM_CH];
    if (avs_address == ADDR_W'(ADDR_CTRL)) begin
      rd_mux_c            = '0;
      rd_mux_c[CTRL_EN]   = ctrl_en_q;
      rd_mux_c[CTRL_AUTO] = ctrl_auto_q;
      rd_mux_c[CTRL_BUSY] = busy;
    end else if (avs_address == ADDR_W'(ADDR_CLKDIV)) begin
      rd_mux_c = BUS_W'(clkdiv_q);
    end
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      avs_readdata <= '0;
    end else begin
      avs_readdata <= avs_read ? rd_mux_c : '0;
    end
  end

  assign led_en = ctrl_en_q;

  led_serializer #(
    .NUM_BITS (NUM_BITS),
    .DIV_W    (DIV_W)
  ) u_serializer (
    .csi_clk   (csi_clk),
    .rsi_reset (rsi_reset),
    .start     (start_c),
    .div       (clkdiv_q),
    .frame     (ch_q),
    .sclk      (led_sclk),
    .sdata     (led_sdata),
    .latch     (led_latch),
    .busy      (busy),
    .done      (frame_done)
  );

endmodule

// File: tb/tb_led_shift_driver.sv
// Scoreboard bench for led_shift_driver: stimulus queues expected reads and frames, a monitor
// decodes the LED pins and Avalon readback and checks them against the queued expectations.
module tb_led_shift_driver;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned DEF_DIV = 4;
  localparam int unsigned NB      = NUM_CH * DATA_W;

  logic              csi_clk       = 1'b0;
  logic              rsi_reset     = 1'b0;
  logic [ADDR_W-1:0] avs_address   = '0;
  logic              avs_write     = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic              avs_read      = 1'b0;
  logic [31:0]       avs_readdata;
  logic              led_sclk, led_sdata, led_latch, led_en, frame_done;

  led_shift_driver #(
    .NUM_CH (NUM_CH), .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DIV_W (DIV_W), .DEF_DIV (DEF_DIV)
  ) dut (
    .csi_clk       (csi_clk),
    .rsi_reset     (rsi_reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .led_sclk      (led_sclk),
    .led_sdata     (led_sdata),
    .led_latch     (led_latch),
    .led_en        (led_en),
    .frame_done    (frame_done)
  );

  always #5 csi_clk = ~csi_clk;

  typedef struct {
    logic [NB-1:0] bits;
    int unsigned   div;
    int unsigned   len;
  } frame_t;

  frame_t      exp_frames[$];
  logic [31:0] exp_rd[$];
  int          errors = 0;
  int          checks = 0;

  // Bus-side model state, updated on the same edges the DUT samples the bus
  logic trig = 1'b0, model_auto = 1'b0, model_en = 1'b0, rd_vld = 1'b0;

  // Pin decoder state
  bit            in_frame = 1'b0, start_next = 1'b0, end_req = 1'b0, end_ack = 1'b0;
  int unsigned   len, run, nbits, phase_bad, cur_div;
  logic [NB-1:0] got_bits;
  logic [1:0]    lvl, prev_lvl;
  logic          prev_sdata;
  frame_t        f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      trig       <= 1'b0;
      model_auto <= 1'b0;
      model_en   <= 1'b0;
      rd_vld     <= 1'b0;
    end else begin
      trig <= avs_write && (avs_address == 4'd0) && avs_writedata[1];
      if (avs_write && (avs_address == 4'd0)) begin
        model_en   <= avs_writedata[0];
        model_auto <= avs_writedata[2];
      end
      rd_vld <= avs_read;
    end
  end

  // Monitor: all comparisons happen here
  always @(negedge csi_clk) begin
    if (rsi_reset) begin
      chk("reset_pins", 32'({led_sclk, led_sdata, led_latch, led_en, frame_done}), 32'd0);
      chk("reset_readdata", avs_readdata, 32'd0);
      in_frame   = 1'b0;
      start_next = 1'b0;
    end else begin
      chk("led_en", 32'(led_en), 32'(model_en));

      if (rd_vld) begin
        if (exp_rd.size() == 0) chk("read_queue_size", 32'(exp_rd.size()), 32'd1);
        else chk("readdata", avs_readdata, exp_rd.pop_front());
      end

      if (!in_frame) begin
        if (trig || start_next) begin
          in_frame   = 1'b1;
          len        = 0;
          run        = 0;
          nbits      = 0;
          phase_bad  = 0;
          got_bits   = '0;
          prev_lvl   = 2'b00;
          prev_sdata = led_sdata;
          cur_div    = (exp_frames.size() > 0) ? exp_frames[0].div : 0;
        end else begin
          chk("idle_pins", 32'({led_sclk, led_sdata, led_latch, frame_done}), 32'd0);
        end
        start_next = 1'b0;
      end

      if (in_frame) begin
        if (frame_done) begin
          if (exp_frames.size() == 0) begin
            chk("frame_queue_size", 32'(exp_frames.size()), 32'd1);
          end else begin
            f = exp_frames.pop_front();
            chk("frame_bits", 32'(got_bits), 32'(f.bits));
            chk("frame_nbits", nbits, NB);
            chk("frame_len", len, f.len);
            chk("latch_len", (prev_lvl == 2'b10) ? run : 32'd0, f.div + 1);
            chk("phase_errors", phase_bad, 32'd0);
            chk("done_pins", 32'({led_sclk, led_latch}), 32'd0);
          end
          in_frame   = 1'b0;
          start_next = model_auto;
        end else begin
          lvl = {led_latch, led_sclk};
          len++;
          if (len == 1) begin
            run = 1;
            if (lvl != 2'b00) phase_bad++;
          end else begin
            if (lvl == prev_lvl) begin
              run++;
            end else begin
              if (run != cur_div + 1) phase_bad++;
              run = 1;
            end
            if (led_sdata != prev_sdata && (lvl == prev_lvl || lvl == 2'b01)) phase_bad++;
            if (lvl == 2'b01 && prev_lvl == 2'b00) begin
              got_bits = {got_bits[NB-2:0], led_sdata};
              nbits++;
            end
          end
          if (led_latch && (led_sclk || led_sdata)) phase_bad++;
          prev_lvl   = lvl;
          prev_sdata = led_sdata;
          if (len > 4000) begin
            chk("frame_timeout", len, 32'd4000);
            in_frame = 1'b0;
          end
        end
      end

      if (end_req && !end_ack) begin
        chk("frames_left", 32'(exp_frames.size()), 32'd0);
        chk("reads_left", 32'(exp_rd.size()), 32'd0);
        end_ack = 1'b1;
      end
    end
  end

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge csi_clk); #1;
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] e);
    exp_rd.push_back(e);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge csi_clk); #1;
    avs_read    = 1'b0;
  endtask

  task automatic push_frame(input logic [NB-1:0] bits, input int unsigned div, input int unsigned len_exp);
    frame_t fr;
    fr.bits = bits;
    fr.div  = div;
    fr.len  = len_exp;
    exp_frames.push_back(fr);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((exp_frames.size() != 0 || in_frame) && n < 3000) begin
      @(posedge csi_clk);
      n++;
    end
    if (n >= 3000) begin
      $display("FAIL wait_idle: %0d frames still pending after %0d cycles", exp_frames.size(), n);
      $fatal(1, "frame wait bound expired");
    end
    @(posedge csi_clk); #1;
  endtask

  initial begin
    // Reset values and register map
    #1 rsi_reset = 1'b1;
    repeat (3) @(posedge csi_clk);
    #1 rsi_reset = 1'b0;
    rd(4'd1, 32'd4);
    rd(4'd2, 32'd0);
    rd(4'd15, 32'd0);
    rd(4'd0, 32'd0);
    wr(4'd15, 32'hFFFF_FFFF);
    rd(4'd15, 32'd0);
    wr(4'd1, 32'h0000_0103);
    rd(4'd1, 32'd3);

    // Fastest divider, one-shot frame
    wr(4'd3, 32'h0000_00A5);
    wr(4'd2, 32'hFFFF_FF3C);
    wr(4'd1, 32'd0);
    rd(4'd3, 32'hA5);
    rd(4'd2, 32'h3C);
    push_frame(16'hA53C, 0, 33);
    wr(4'd0, 32'h2);
    wait_idle();

    // Divider 3; channel write and START while busy only affect the next frame
    wr(4'd1, 32'd3);
    push_frame(16'hA53C, 3, 132);
    wr(4'd0, 32'h2);
    repeat (20) @(posedge csi_clk);
    #1;
    wr(4'd2, 32'hFF);
    rd(4'd0, 32'h100);
    wr(4'd0, 32'h2);
    rd(4'd2, 32'hFF);
    wait_idle();
    rd(4'd0, 32'h0);
    push_frame(16'hA5FF, 3, 132);
    wr(4'd0, 32'h2);
    wait_idle();

    // Output enable
    wr(4'd0, 32'h1);
    rd(4'd0, 32'h1);
    repeat (3) @(posedge csi_clk);
    #1;
    wr(4'd0, 32'h0);

    // AUTO: back-to-back frames, cleared during the second one
    wr(4'd1, 32'd0);
    push_frame(16'hA5FF, 0, 33);
    push_frame(16'hA5FF, 0, 33);
    wr(4'd0, 32'h6);
    repeat (44) @(posedge csi_clk);
    #1;
    wr(4'd0, 32'h0);
    wait_idle();
    repeat (40) @(posedge csi_clk);
    #1;

    // Asynchronous reset in the middle of a frame
    wr(4'd0, 32'h2);
    repeat (10) @(posedge csi_clk);
    #2 rsi_reset = 1'b1;
    repeat (2) @(posedge csi_clk);
    #1 rsi_reset = 1'b0;
    rd(4'd0, 32'h0);
    rd(4'd2, 32'h0);
    rd(4'd1, 32'd4);
    repeat (40) @(posedge csi_clk);
    #1;

    end_req = 1'b1;
    repeat (3) @(posedge csi_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
